mult_cmd_sequencer: RTL and testbench

- Synthesizable command sequencer for one multi-exponentiation pass across N parallel mult_unit instances and one table_control.
- Replaces hand-timed command pulses with an idle-handshaked state machine: INIT, then FIRST with table start, then E_WORDS-1 NEXT, then FINISH.
- Generalised over unit count, exponent words and guard timing.
- Sits between the host/control logic and the mult_unit array.

---
 rtl/mult_seq_pkg.sv | 28 ++
 rtl/seq_guard_timer.sv | 34 +++
 rtl/mult_cmd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_mult_cmd_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared opcodes and FSM state encoding for the multi-exponentiation command sequencer.
package mult_seq_pkg;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_FIRST  = 3'b010;
  localparam logic [2:0] CMD_NEXT   = 3'b011;
  localparam logic [2:0] CMD_INIT   = 3'b100;
  localparam logic [2:0] CMD_FINISH = 3'b101;

  localparam logic [1:0] TCMD_NOP   = 2'b00;
  localparam logic [1:0] TCMD_START = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FIRST  = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6
  } seq_state_t;

  // States that emit a command pulse and arm the wait timers.
  function automatic logic is_pulse_state(input seq_state_t s);
    return (s inside {S_INIT, S_FIRST, S_NEXT, S_FINISH});
  endfunction

endpackage

// File: rtl/seq_guard_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module seq_guard_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         ctrl_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mult_cmd_sequencer.sv
// Idle-handshaked command sequencer for one multi-exponentiation pass over a mult_unit array.
// Optional per-wait watchdog enabled with `define SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet
// S_INIT   | issue CMD_INIT
// S_FIRST  | issue CMD_FIRST with TCMD_START, word_idx = 0
// S_NEXT   | issue CMD_NEXT, word_idx + 1
// S_FINISH | issue CMD_FINISH
// S_WAIT   | guard cycles, then hold until participating units ready
// S_DONE   | done pulse, then back to idle
module mult_cmd_sequencer
  import mult_seq_pkg::*;
#(
  parameter int N_UNITS = 2,
  parameter int E_WORDS = 4,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                             clk,
  input  logic                             ctrl_reset_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [N_UNITS-1:0]               unit_mask,
  input  logic [N_UNITS-1:0]               unit_idle,
  input  logic                             t_idle,
  output logic [2:0]                       command,
  output logic [1:0]                       tcmd,
  output logic [$clog2(E_WORDS+1)-1:0]     word_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int                IDX_W     = $clog2(E_WORDS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(E_WORDS - 1);
  localparam logic [2:0]        GUARD_VAL = 3'(GUARD);

  seq_state_t         state_q, state_d;
  logic [N_UNITS-1:0] mask_q, mask_d;
  logic [2:0]         command_q, command_d;
  logic [2:0]         last_cmd_q, last_cmd_d;
  logic [1:0]         tcmd_q, tcmd_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               done_q, done_d;

  logic units_ready;
  logic wait_ready;
  logic in_wait;
  logic guard_load;
  logic guard_exp;
  logic start_acc;
  logic timeout;

  assign in_wait     = (state_q == S_WAIT);
  assign guard_load  = is_pulse_state(state_q);
  assign start_acc   = (state_q == S_IDLE) && start && !abort;
  assign units_ready = &(unit_idle | ~mask_q);
  // Table control only has work after FIRST/NEXT, so only those waits look at t_idle.
  assign wait_ready  = units_ready &&
                       (t_idle || !((last_cmd_q == CMD_FIRST) || (last_cmd_q == CMD_NEXT)));

  seq_guard_timer #(.W(3)) u_guard (
    .clk          (clk),
    .ctrl_reset_n (ctrl_reset_n),
    .load         (guard_load),
    .load_val     (GUARD_VAL),
    .en           (in_wait),
    .expired      (guard_exp)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic wd_exp;
  logic error_q, error_d;

  // Counts only post-guard cycles that are still waiting; expires on the TIMEOUT-th one.
  seq_guard_timer #(.W(WD_W)) u_watchdog (
    .clk          (clk),
    .ctrl_reset_n (ctrl_reset_n),
    .load         (guard_load),
    .load_val     (WD_W'(TIMEOUT - 1)),
    .en           (in_wait && guard_exp && !wait_ready),
    .expired      (wd_exp)
  );

  assign timeout = in_wait && guard_exp && !wait_ready && wd_exp;

  always_comb begin
    error_d = error_q;
    if (start_acc) begin
      error_d = 1'b0;
    end
    if (timeout && !abort) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    command_d  = CMD_NOP;
    tcmd_d     = TCMD_NOP;
    word_idx_d = word_idx_q;
    last_cmd_d = last_cmd_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          mask_d  = unit_mask;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        command_d  = CMD_INIT;
        last_cmd_d = CMD_INIT;
        state_d    = S_WAIT;
      end
      S_FIRST: begin
        command_d  = CMD_FIRST;
        tcmd_d     = TCMD_START;
        word_idx_d = '0;
        last_cmd_d = CMD_FIRST;
        state_d    = S_WAIT;
      end
      S_NEXT: begin
        command_d  = CMD_NEXT;
        word_idx_d = word_idx_q + 1'b1;
        last_cmd_d = CMD_NEXT;
        state_d    = S_WAIT;
      end
      S_FINISH: begin
        command_d  = CMD_FINISH;
        last_cmd_d = CMD_FINISH;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (timeout) begin
          state_d    = S_IDLE;
          word_idx_d = '0;
        end else if (guard_exp && wait_ready) begin
          case (last_cmd_q)
            CMD_INIT:   state_d = S_FIRST;
            CMD_FINISH: begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
            default:    state_d = (word_idx_q < LAST_IDX) ? S_NEXT : S_FINISH;
          endcase
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        word_idx_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      command_d  = CMD_NOP;
      tcmd_d     = TCMD_NOP;
      word_idx_d = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      command_q  <= CMD_NOP;
      tcmd_q     <= TCMD_NOP;
      word_idx_q <= '0;
      last_cmd_q <= CMD_NOP;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      command_q  <= command_d;
      tcmd_q     <= tcmd_d;
      word_idx_q <= word_idx_d;
      last_cmd_q <= last_cmd_d;
      done_q     <= done_d;
    end
  end

  assign command  = command_q;
  assign tcmd     = tcmd_q;
  assign word_idx = word_idx_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_mult_cmd_sequencer.sv
// Directed bench for mult_cmd_sequencer with a per-DUT expected-pulse scoreboard.
module tb_mult_cmd_sequencer;
  import mult_seq_pkg::*;

  localparam int NU = 2;
  localparam int EW = 4;
  localparam int GD = 2;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  typedef struct packed {
    logic [2:0] cmd;
    logic [1:0] tcmd;
    logic [2:0] widx;
    logic       done;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [1:0] mask0 = 2'b11, mask1 = 2'b11, uidle1 = 2'b11;
  logic       tidle1 = 1'b1;
  logic [1:0] uhold = 2'b00;
  logic       thold = 1'b0;
  logic [1:0] uidle0;
  logic       tidle0;
  logic [2:0] command0, command1;
  logic [1:0] tcmd0, tcmd1;
  logic [2:0] widx0;
  logic [0:0] widx1;
  logic       busy0, done0, err0, busy1, done1, err1;

  int   checks = 0, errors = 0, cyc = 0, resp_cnt = 0, nxt1 = 0;
  rec_t exp0[$];
  rec_t exp1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Array/table idle model: busy for 3 cycles after any command, plus forced-low holds.
  always @(negedge clk) begin
    if (command0 != CMD_NOP) resp_cnt = 3;
    else if (resp_cnt > 0) resp_cnt--;
  end
  assign uidle0 = {2{resp_cnt == 0}} & ~uhold;
  assign tidle0 = (resp_cnt == 0) && !thold;

  mult_cmd_sequencer #(.N_UNITS(NU), .E_WORDS(EW), .GUARD(GD), .TIMEOUT(TO)) dut0 (
    .clk(clk), .ctrl_reset_n(rst_n), .start(start0), .abort(abort0),
    .unit_mask(mask0), .unit_idle(uidle0), .t_idle(tidle0),
    .command(command0), .tcmd(tcmd0), .word_idx(widx0),
    .busy(busy0), .done(done0), .error(err0)
  );

  mult_cmd_sequencer #(.N_UNITS(NU), .E_WORDS(1), .GUARD(GD), .TIMEOUT(TO)) dut1 (
    .clk(clk), .ctrl_reset_n(rst_n), .start(start1), .abort(abort1),
    .unit_mask(mask1), .unit_idle(uidle1), .t_idle(tidle1),
    .command(command1), .tcmd(tcmd1), .word_idx(widx1),
    .busy(busy1), .done(done1), .error(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int id, input rec_t r);
    if (id == 0) exp0.push_back(r);
    else exp1.push_back(r);
  endtask

  task automatic push_pass(input int id, input int ew);
    rec_t r;
    r = '{cmd: CMD_INIT, tcmd: TCMD_NOP, widx: 3'd0, done: 1'b0};     push(id, r);
    r = '{cmd: CMD_FIRST, tcmd: TCMD_START, widx: 3'd0, done: 1'b0};  push(id, r);
    for (int k = 1; k < ew; k++) begin
      r = '{cmd: CMD_NEXT, tcmd: TCMD_NOP, widx: 3'(k), done: 1'b0};  push(id, r);
    end
    r = '{cmd: CMD_FINISH, tcmd: TCMD_NOP, widx: 3'(ew - 1), done: 1'b0}; push(id, r);
    r = '{cmd: CMD_NOP, tcmd: TCMD_NOP, widx: 3'(ew - 1), done: 1'b1};    push(id, r);
  endtask

  task automatic observe(input int id, input rec_t obs);
    rec_t e;
    e = '1;
    if (id == 0) begin
      if (exp0.size() != 0) e = exp0.pop_front();
    end else begin
      if (exp1.size() != 0) e = exp1.pop_front();
    end
    chk($sformatf("seq%0d", id), 32'(obs), 32'(e));
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (rst_n && (command0 != CMD_NOP || tcmd0 != TCMD_NOP || done0)) begin
      r.cmd = command0; r.tcmd = tcmd0; r.widx = widx0; r.done = done0;
      observe(0, r);
    end
    if (rst_n && (command1 != CMD_NOP || tcmd1 != TCMD_NOP || done1)) begin
      r.cmd = command1; r.tcmd = tcmd1; r.widx = {2'b00, widx1}; r.done = done1;
      observe(1, r);
    end
    if (command1 == CMD_NEXT) nxt1++;
  end

  task automatic wait_cmd(input logic [2:0] c, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      if (command0 === c) begin hit = 1'b1; at = cyc; end
    end
    chk($sformatf("wait_cmd_%0h", c), 32'(hit), 32'd1);
  endtask

  task automatic wait_done(input int id, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      if ((id == 0) ? done0 : done1) hit = 1'b1;
    end
    chk($sformatf("wait_done%0d", id), 32'(hit), 32'd1);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t_first, t_next, n_done;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_command", 32'(command0), 32'(CMD_NOP));
    chk("rst_tcmd",    32'(tcmd0),    32'(TCMD_NOP));
    chk("rst_word_idx", 32'(widx0),   32'd0);
    chk("rst_busy",    32'(busy0),    32'd0);
    chk("rst_done",    32'(done0),    32'd0);
    chk("rst_error",   32'(err0),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full pass, both units, with latency check
    push_pass(0, EW);
    pulse_start0();
    chk("lat_busy", 32'(busy0), 32'd1);
    chk("lat_cmd_early", 32'(command0), 32'(CMD_NOP));
    @(posedge clk); #1;
    chk("lat_cmd_init", 32'(command0), 32'(CMD_INIT));
    wait_done(0, 200);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy0), 32'd0);
    chk("q_empty_full", 32'(exp0.size()), 32'd0);

    // Single exponent word
    push_pass(1, 1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1, 200);
    @(posedge clk); #1;
    chk("ew1_busy", 32'(busy1), 32'd0);
    chk("ew1_error", 32'(err1), 32'd0);
    chk("ew1_no_next", 32'(nxt1), 32'd0);
    chk("q_empty_ew1", 32'(exp1.size()), 32'd0);

    // Masked-out unit stuck busy; unit 0 stalls 50 cycles after FIRST
    mask0 = 2'b01;
    uhold = 2'b10;
    push_pass(0, EW);
    pulse_start0();
    wait_cmd(CMD_FIRST, 100, t_first);
    uhold[0] = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    uhold[0] = 1'b0;
    wait_cmd(CMD_NEXT, 100, t_next);
    chk("stall_gap_ge50", 32'(t_next - t_first >= 50), 32'd1);
    wait_done(0, 200);
    uhold = 2'b00;
    @(posedge clk); #1;
    chk("q_empty_mask01", 32'(exp0.size()), 32'd0);

    // Empty mask, all units stuck busy
    mask0 = 2'b00;
    uhold = 2'b11;
    push_pass(0, EW);
    pulse_start0();
    wait_done(0, 200);
    uhold = 2'b00;
    mask0 = 2'b11;
    @(posedge clk); #1;
    chk("q_empty_mask00", 32'(exp0.size()), 32'd0);

    // Abort during the third wait phase
    push_pass(0, EW);
    pulse_start0();
    wait_cmd(CMD_NEXT, 100, t_next);
    @(posedge clk); #1;
    abort0 = 1'b1;
    exp0.delete();
    @(posedge clk); #1;
    abort0 = 1'b0;
    chk("abort_command", 32'(command0), 32'(CMD_NOP));
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_word_idx", 32'(widx0), 32'd0);
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);

    // Abort coincident with start
    abort0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    start0 = 1'b0;
    chk("abort_start_busy", 32'(busy0), 32'd0);

    // Clean pass with a stray start while busy
    push_pass(0, EW);
    pulse_start0();
    repeat (3) @(posedge clk);
    #1;
    pulse_start0();
    wait_done(0, 200);
    @(posedge clk); #1;
    chk("q_empty_clean", 32'(exp0.size()), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    begin
      rec_t r;
      int t_err;
      bit hit;
      thold = 1'b1;
      r = '{cmd: CMD_INIT, tcmd: TCMD_NOP, widx: 3'd0, done: 1'b0};    push(0, r);
      r = '{cmd: CMD_FIRST, tcmd: TCMD_START, widx: 3'd0, done: 1'b0}; push(0, r);
      pulse_start0();
      wait_cmd(CMD_FIRST, 100, t_first);
      hit = 1'b0;
      t_err = -1;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(posedge clk); #1;
        if (err0) begin hit = 1'b1; t_err = cyc; end
      end
      chk("to_error_set", 32'(hit), 32'd1);
      chk("to_cycles", 32'(t_err - t_first), 32'(GD + TO));
      chk("to_busy", 32'(busy0), 32'd0);
      thold = 1'b0;
      chk("q_empty_to", 32'(exp0.size()), 32'd0);
      push_pass(0, EW);
      pulse_start0();
      chk("to_error_cleared", 32'(err0), 32'd0);
      wait_done(0, 200);
    end
`endif

    // Reset asserted mid-NEXT pulse
    push_pass(0, EW);
    pulse_start0();
    wait_cmd(CMD_NEXT, 100, t_next);
    #2;
    rst_n = 1'b0;
    exp0.delete();
    #1;
    chk("rst_mid_command", 32'(command0), 32'(CMD_NOP));
    chk("rst_mid_tcmd", 32'(tcmd0), 32'(TCMD_NOP));
    chk("rst_mid_word_idx", 32'(widx0), 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    chk("rst_mid_done", 32'(done0), 32'd0);
    chk("rst_mid_error", 32'(err0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
